// File: rtl/mm_spart.sv
// mm_spart: memory-mapped 8N1 UART with TX/RX FIFOs, status and baud divisor.
//
// TX/RX FSM states
//   state    | meaning
//   ST_IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
//   ST_START | start bit (TX drives 0; RX waits half a bit then checks for glitch)
//   ST_DATA  | 8 data bits, LSB first, one per bit period
//   ST_STOP  | stop bit (TX drives 1; RX samples and pushes or flags an error)
module mm_spart #(
  parameter logic [15:0] BASE       = 16'hC000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RST    = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  output logic [15:0] rdata,
  output logic        txd,
  input  logic        rxd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   A_DATA   = BASE;
  localparam logic [15:0]   A_STAT   = BASE + 16'd1;
  localparam logic [15:0]   A_DIV    = BASE + 16'd2;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    tx_mem_d [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [15:0]   div_q, div_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;

  uart_st_e      tx_st_q, tx_st_d;
  logic [15:0]   tx_tmr_q, tx_tmr_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;

  uart_st_e      rx_st_q, rx_st_d;
  logic [15:0]   rx_tmr_q, rx_tmr_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;

  logic hit_data, hit_stat, hit_div;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_done, rx_bad;
  logic [15:0] eff_div, status;

  assign hit_data = (addr == A_DATA);
  assign hit_stat = (addr == A_STAT);
  assign hit_div  = (addr == A_DIV);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  // Divisors below 4 would leave no room for the half-bit RX start check.
  assign eff_div  = (div_q < 16'd4) ? 16'd4 : div_q;
  assign status   = {10'b0, ferr_q, ovr_q, rx_full, rx_empty, tx_empty, tx_full};
  assign txd      = txd_q;

  // Combinational read mux so the CPU captures data in the strobe cycle.
  always_comb begin
    rdata = 16'h0000;
    if (mm_re) begin
      if (hit_data && !rx_empty) rdata = {8'h00, rx_mem_q[rx_rd_q]};
      else if (hit_stat)         rdata = status;
      else if (hit_div)          rdata = div_q;
    end
  end

  // TX FSM: each bit timer is loaded from the divisor at the bit boundary.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_tmr_d = tx_tmr_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_mem_q[tx_rd_q];
          tx_tmr_d = eff_div - 16'd1;
          txd_d    = 1'b0;
          tx_st_d  = ST_START;
        end
      end
      ST_START: begin
        if (tx_tmr_q == 16'd0) begin
          tx_tmr_d = eff_div - 16'd1;
          tx_bit_d = 3'd0;
          txd_d    = tx_sh_q[0];
          tx_st_d  = ST_DATA;
        end else tx_tmr_d = tx_tmr_q - 16'd1;
      end
      ST_DATA: begin
        if (tx_tmr_q == 16'd0) begin
          tx_tmr_d = eff_div - 16'd1;
          if (tx_bit_q == 3'd7) begin
            txd_d   = 1'b1;
            tx_st_d = ST_STOP;
          end else begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else tx_tmr_d = tx_tmr_q - 16'd1;
      end
      ST_STOP: begin
        if (tx_tmr_q == 16'd0) tx_st_d = ST_IDLE;
        else tx_tmr_d = tx_tmr_q - 16'd1;
      end
      default: begin
        tx_st_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // RX FSM: samples near bit centres after a half-bit start delay.
  always_comb begin
    rx_meta_d = rxd;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    rx_st_d   = rx_st_q;
    rx_tmr_d  = rx_tmr_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_done   = 1'b0;
    rx_bad    = 1'b0;
    case (rx_st_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_tmr_d = (eff_div >> 1) - 16'd1;
          rx_st_d  = ST_START;
        end
      end
      ST_START: begin
        if (rx_tmr_q == 16'd0) begin
          if (rx_sync_q) rx_st_d = ST_IDLE;
          else begin
            rx_tmr_d = eff_div - 16'd1;
            rx_bit_d = 3'd0;
            rx_st_d  = ST_DATA;
          end
        end else rx_tmr_d = rx_tmr_q - 16'd1;
      end
      ST_DATA: begin
        if (rx_tmr_q == 16'd0) begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_tmr_d = eff_div - 16'd1;
          if (rx_bit_q == 3'd7) rx_st_d = ST_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_tmr_d = rx_tmr_q - 16'd1;
      end
      ST_STOP: begin
        if (rx_tmr_q == 16'd0) begin
          rx_st_d = ST_IDLE;
          if (rx_sync_q) rx_done = 1'b1;
          else rx_bad = 1'b1;
        end else rx_tmr_d = rx_tmr_q - 16'd1;
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping, DIV register and sticky status flags.
  always_comb begin
    tx_push  = mm_we && hit_data && (!tx_full || tx_pop);
    rx_pop   = mm_re && hit_data && !rx_empty;
    rx_push  = rx_done && (!rx_full || rx_pop);
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push) tx_mem_d[tx_wr_q] = wdata[7:0];
    if (rx_push) rx_mem_d[rx_wr_q] = rx_sh_q;
    tx_wr_d  = tx_push ? tx_wr_q + AW'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + AW'(1) : tx_rd_q;
    rx_wr_d  = rx_push ? rx_wr_q + AW'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + AW'(1) : rx_rd_q;
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    div_d    = (mm_we && hit_div) ? wdata : div_q;
    // A new event in the same cycle as a STATUS read must not be lost.
    ovr_d    = (rx_done && !rx_push) || (ovr_q && !(mm_re && hit_stat));
    ferr_d   = rx_bad || (ferr_q && !(mm_re && hit_stat));
  end

  // State registers; reset aborts any frame in flight and idles txd high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= 8'h00;
        rx_mem_q[i] <= 8'h00;
      end
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      div_q     <= DIV_RST;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      tx_st_q   <= ST_IDLE;
      tx_tmr_q  <= 16'd0;
      tx_bit_q  <= 3'd0;
      tx_sh_q   <= 8'h00;
      txd_q     <= 1'b1;
      rx_st_q   <= ST_IDLE;
      rx_tmr_q  <= 16'd0;
      rx_bit_q  <= 3'd0;
      rx_sh_q   <= 8'h00;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      tx_mem_q  <= tx_mem_d;
      rx_mem_q  <= rx_mem_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      div_q     <= div_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      tx_st_q   <= tx_st_d;
      tx_tmr_q  <= tx_tmr_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      txd_q     <= txd_d;
      rx_st_q   <= rx_st_d;
      rx_tmr_q  <= rx_tmr_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
    end
  end

endmodule

// File: tb/tb_mm_spart.sv
// tb_mm_spart: directed bench for the memory-mapped UART.
module tb_mm_spart;

  localparam logic [15:0] BASE    = 16'hC000;
  localparam logic [15:0] A_DATA  = BASE;
  localparam logic [15:0] A_STAT  = BASE + 16'd1;
  localparam logic [15:0] A_DIV   = BASE + 16'd2;
  localparam logic [15:0] DIV_RST = 16'd434;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr, wdata, rdata;
  logic        mm_we, mm_re, txd, rxd;

  int n_vec = 0;
  int n_err = 0;

  logic       mon_en = 1'b0;
  logic [7:0] mon_byte;
  logic [8:0] mon_q[$];

  mm_spart #(.BASE(BASE), .FIFO_DEPTH(4), .DIV_RST(DIV_RST)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mm_we(mm_we),
    .mm_re(mm_re), .rdata(rdata), .txd(txd), .rxd(rxd)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  // Serial monitor on txd (DIV=16): samples mid-bit, stores {stop, byte}.
  always begin
    @(negedge clk);
    if (mon_en && txd === 1'b0) begin
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        mon_byte[i] = txd;
      end
      repeat (16) @(negedge clk);
      mon_q.push_back({txd, mon_byte});
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; mm_we = 1'b1;
    @(negedge clk);
    mm_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; mm_re = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    mm_re = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  a5;
    int t, lo;
    rst_n = 1'b0; addr = 16'h0; wdata = 16'h0; mm_we = 1'b0; mm_re = 1'b0; rxd = 1'b1;
    a5 = 8'hA5;
    wait_clks(3);
    check("rst_txd", 16'(txd), 16'h0001);
    rst_n = 1'b1;
    bus_rd(A_STAT, d); check("rst_status", d, 16'h0006);
    bus_rd(A_DIV, d);  check("rst_div", d, DIV_RST);

    // Reset in the middle of a frame of 0x00.
    bus_wr(A_DIV, 16'd16);
    bus_wr(A_DATA, 16'h0000);
    wait_clks(60);
    check("midframe_txd_low", 16'(txd), 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("reset_txd_async", 16'(txd), 16'h0001);
    wait_clks(2);
    rst_n = 1'b1;
    bus_rd(A_STAT, d); check("post_rst_status", d, 16'h0006);
    bus_rd(A_DIV, d);  check("post_rst_div", d, DIV_RST);
    lo = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lo++;
    end
    check("post_rst_txd_idle", 16'(lo), 16'd0);

    // TX of 0xA5 at DIV=16.
    bus_wr(A_DIV, 16'd16);
    bus_rd(A_DIV, d); check("div_rdback", d, 16'd16);
    bus_wr(A_DATA, 16'h00A5);
    t = 0;
    while (txd !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    check("tx_start_seen", 16'(t < 50), 16'h0001);
    lo = 0;
    while (txd === 1'b0 && lo < 100) begin lo++; @(negedge clk); end
    check("tx_start_len", 16'(lo), 16'd16);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_a5_bit%0d", i), 16'(txd), 16'(a5[i]));
      repeat (16) @(negedge clk);
    end
    check("tx_a5_stop", 16'(txd), 16'h0001);
    wait_clks(20);
    bus_rd(A_STAT, d); check("tx_done_status", d, 16'h0006);

    // TX FIFO full: 5 back-to-back writes, later 0x06 fits, 0x07 dropped.
    wait_clks(20);
    mon_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    addr = A_DATA; wdata = 16'h0001; mm_we = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      wdata = 16'(i);
    end
    @(negedge clk);
    mm_we = 1'b0;
    bus_rd(A_STAT, d); check("tx_full_after5", d, 16'h0005);
    t = 0;
    while (mon_q.size() < 1 && t < 400) begin @(negedge clk); t++; end
    check("tx_first_frame", 16'(mon_q.size()), 16'd1);
    wait_clks(20);
    bus_wr(A_DATA, 16'h0006);
    bus_rd(A_STAT, d); check("tx_full_after6", d, 16'h0005);
    bus_wr(A_DATA, 16'h0007);
    bus_rd(A_STAT, d); check("tx_full_after7", d, 16'h0005);
    t = 0;
    while (mon_q.size() < 6 && t < 1500) begin @(negedge clk); t++; end
    wait_clks(400);
    check("tx_frame_count", 16'(mon_q.size()), 16'd6);
    for (int i = 0; i < 6 && i < mon_q.size(); i++)
      check($sformatf("tx_frame%0d", i), 16'(mon_q[i]), 16'h0100 | 16'(i + 1));
    mon_en = 1'b0;

    // RX of 0x3C.
    send_rx(8'h3C, 1'b1);
    bus_rd(A_STAT, d); check("rx_avail_status", d, 16'h0002);
    bus_rd(A_DATA, d); check("rx_byte_3c", d, 16'h003C);
    bus_rd(A_DATA, d); check("rx_empty_read", d, 16'h0000);
    bus_rd(A_STAT, d); check("rx_empty_status", d, 16'h0006);

    // Overrun: five bytes, no reads.
    for (int i = 0; i < 5; i++) send_rx(8'h11 + 8'(i), 1'b1);
    bus_rd(A_STAT, d); check("ovr_status1", d, 16'h001A);
    bus_rd(A_STAT, d); check("ovr_status2", d, 16'h000A);
    for (int i = 0; i < 4; i++) begin
      bus_rd(A_DATA, d);
      check($sformatf("ovr_drain%0d", i), d, 16'h0011 + 16'(i));
    end
    bus_rd(A_STAT, d); check("drained_status", d, 16'h0006);

    // Frame error: stop bit low.
    send_rx(8'h81, 1'b0);
    bus_rd(A_STAT, d); check("ferr_status1", d, 16'h0026);
    bus_rd(A_STAT, d); check("ferr_status2", d, 16'h0006);
    bus_rd(A_DATA, d); check("ferr_no_push", d, 16'h0000);

    // Glitch on rxd, then a good byte.
    @(negedge clk);
    rxd = 1'b0;
    wait_clks(4);
    rxd = 1'b1;
    wait_clks(60);
    bus_rd(A_STAT, d); check("glitch_status", d, 16'h0006);
    send_rx(8'h5A, 1'b1);
    bus_rd(A_DATA, d); check("after_glitch_rx", d, 16'h005A);

    // Unmapped and read-only accesses.
    bus_rd(16'hC003, d); check("unmapped_rd", d, 16'h0000);
    bus_wr(16'hC001, 16'hFFFF);
    bus_rd(A_STAT, d); check("stat_wr_ignored", d, 16'h0006);
    bus_wr(16'hC003, 16'h0002);
    bus_rd(A_DIV, d); check("unmapped_wr_div", d, 16'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
